// File: rtl/vdma_burst_scheduler.sv
// vdma_burst_scheduler: shares one AXI burst engine between write and read channels.
// Write and read directions alternate. Channels within each direction are served round-robin.
// A grant is held until the engine reports done or the watchdog expires.
// Ports:
//   clock, rst_n           - clock, asynchronous active-low reset
//   wr_req / rd_req        - per-channel level burst requests
//   wr_done / rd_done      - engine pulses ending the current write / read burst
//   timeout_clr            - clears the sticky timeout_err flag
//   wr_grant / rd_grant    - registered one-hot grants
//   wr_start / rd_start    - pulse in the first cycle of a grant
//   busy                   - a burst is being executed
//   timeout_err            - sticky watchdog flag
module vdma_burst_scheduler #(
    parameter int NUM_WR  = 2,
    parameter int NUM_RD  = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [NUM_WR-1:0] wr_req,
    input  logic [NUM_RD-1:0] rd_req,
    input  logic              wr_done,
    input  logic              rd_done,
    input  logic              timeout_clr,
    output logic [NUM_WR-1:0] wr_grant,
    output logic [NUM_RD-1:0] rd_grant,
    output logic              wr_start,
    output logic              rd_start,
    output logic              busy,
    output logic              timeout_err
);
    localparam int WW = NUM_WR > 1 ? $clog2(NUM_WR) : 1;
    localparam int RW = NUM_RD > 1 ? $clog2(NUM_RD) : 1;
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WR_EXEC, RD_EXEC} state_t;

    state_t        state, state_nx;
    logic          pref_rd;
    logic [WW-1:0] wr_ptr, wr_idx, wr_win;
    logic [RW-1:0] rd_ptr, rd_idx, rd_win;
    logic [CW-1:0] wdog;
    logic          wr_hit, rd_hit, expire, wr_end, rd_end, wr_go, rd_go, to_hit;

    // Scanning a doubled index range from ptr upward gives the wrap-around search
    // without a modulo on a variable.
    always_comb begin
        wr_win = wr_ptr;
        wr_hit = 1'b0;
        for (int i = 0; i < 2 * NUM_WR; i++)
            if (!wr_hit && i >= int'(wr_ptr) && wr_req[i % NUM_WR]) begin
                wr_hit = 1'b1;
                wr_win = WW'(i % NUM_WR);
            end
    end

    always_comb begin
        rd_win = rd_ptr;
        rd_hit = 1'b0;
        for (int i = 0; i < 2 * NUM_RD; i++)
            if (!rd_hit && i >= int'(rd_ptr) && rd_req[i % NUM_RD]) begin
                rd_hit = 1'b1;
                rd_win = RW'(i % NUM_RD);
            end
    end

    assign expire = wdog == CW'(TIMEOUT - 1);
    assign wr_end = state == WR_EXEC && (wr_done || expire);
    assign rd_end = state == RD_EXEC && (rd_done || expire);
    // A done pulse coinciding with expiry is a normal completion.
    assign to_hit = expire && ((state == WR_EXEC && !wr_done) || (state == RD_EXEC && !rd_done));
    assign wr_go  = state == IDLE && state_nx == WR_EXEC;
    assign rd_go  = state == IDLE && state_nx == RD_EXEC;

    always_ff @(posedge clock or negedge rst_n)
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:
                if (wr_hit && (!pref_rd || !rd_hit))
                    state_nx = WR_EXEC;
                else if (rd_hit)
                    state_nx = RD_EXEC;
            WR_EXEC: state_nx = wr_end ? IDLE : WR_EXEC;
            RD_EXEC: state_nx = rd_end ? IDLE : RD_EXEC;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n)
        if (!rst_n) begin
            wr_grant    <= '0;
            rd_grant    <= '0;
            wr_start    <= 1'b0;
            rd_start    <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            pref_rd     <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            wr_idx      <= '0;
            rd_idx      <= '0;
            wdog        <= '0;
        end else begin
            wr_start    <= wr_go;
            rd_start    <= rd_go;
            busy        <= state_nx != IDLE;
            timeout_err <= to_hit | (timeout_err & ~timeout_clr);
            // Every EXEC exit passes through IDLE, so the count restarts at 0 on entry.
            wdog        <= state == IDLE ? '0 : wdog + 1'b1;
            if (wr_go) begin
                wr_grant <= NUM_WR'(1) << wr_win;
                wr_idx   <= wr_win;
            end else if (wr_end) begin
                wr_grant <= '0;
                wr_ptr   <= wr_idx == WW'(NUM_WR - 1) ? '0 : wr_idx + 1'b1;
                pref_rd  <= 1'b1;
            end
            if (rd_go) begin
                rd_grant <= NUM_RD'(1) << rd_win;
                rd_idx   <= rd_win;
            end else if (rd_end) begin
                rd_grant <= '0;
                rd_ptr   <= rd_idx == RW'(NUM_RD - 1) ? '0 : rd_idx + 1'b1;
                pref_rd  <= 1'b0;
            end
        end
endmodule

// File: tb/tb_vdma_burst_scheduler.sv
// tb_vdma_burst_scheduler: table vectors, hand sequences and random stimulus against a reference model.
module tb_vdma_burst_scheduler;
    localparam int NW = 3;
    localparam int NR = 2;
    localparam int TO = 8;

    logic          clock = 1'b0;
    logic          rst_n = 1'b0;
    logic [NW-1:0] wr_req = '0;
    logic [NR-1:0] rd_req = '0;
    logic          wr_done = 1'b0, rd_done = 1'b0, timeout_clr = 1'b0;
    logic [NW-1:0] wr_grant;
    logic [NR-1:0] rd_grant;
    logic          wr_start, rd_start, busy, timeout_err;
    logic [8:0]    obs;

    int n_chk = 0;
    int n_pass = 0;

    vdma_burst_scheduler #(.NUM_WR(NW), .NUM_RD(NR), .TIMEOUT(TO)) dut (
        .clock(clock), .rst_n(rst_n), .wr_req(wr_req), .rd_req(rd_req),
        .wr_done(wr_done), .rd_done(rd_done), .timeout_clr(timeout_clr),
        .wr_grant(wr_grant), .rd_grant(rd_grant), .wr_start(wr_start),
        .rd_start(rd_start), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    assign obs = {wr_grant, rd_grant, wr_start, rd_start, busy, timeout_err};

    typedef struct {
        logic [2:0] w;
        logic [1:0] r;
        logic       wd, rdn, cl;
        logic [8:0] exp;
    } vec_t;

    // Reference model: who owns the engine, for how long, and the fairness bookkeeping.
    int m_dir, m_own, m_age, m_pref, m_wp, m_rp;
    bit m_sw, m_sr, m_err;

    function automatic int pick(logic [7:0] req, int ptr, int n);
        for (int i = 0; i < n; i++)
            if (req[(ptr + i) % n]) return (ptr + i) % n;
        return 0;
    endfunction

    task automatic model_reset();
        m_dir = 0; m_own = 0; m_age = 0; m_pref = 0; m_wp = 0; m_rp = 0;
        m_sw = 0; m_sr = 0; m_err = 0;
    endtask

    task automatic model_step();
        bit eset = 0;
        bit any_w = |wr_req;
        bit any_r = |rd_req;
        bit dn;
        m_sw = 0;
        m_sr = 0;
        if (m_dir == 0) begin
            if (any_w && (m_pref == 0 || !any_r)) begin
                m_dir = 1; m_own = pick({5'b0, wr_req}, m_wp, NW); m_age = 0; m_sw = 1;
            end else if (any_r) begin
                m_dir = 2; m_own = pick({6'b0, rd_req}, m_rp, NR); m_age = 0; m_sr = 1;
            end
        end else begin
            dn = m_dir == 1 ? wr_done : rd_done;
            if (dn || m_age == TO - 1) begin
                eset = !dn;
                if (m_dir == 1) begin m_wp = (m_own + 1) % NW; m_pref = 1; end
                else begin m_rp = (m_own + 1) % NR; m_pref = 0; end
                m_dir = 0;
            end else
                m_age++;
        end
        m_err = eset || (m_err && !timeout_clr);
    endtask

    function automatic logic [8:0] mexp();
        logic [2:0] g = '0;
        logic [1:0] r = '0;
        if (m_dir == 1) g[m_own] = 1'b1;
        if (m_dir == 2) r[m_own] = 1'b1;
        return {g, r, m_sw, m_sr, m_dir != 0, m_err};
    endfunction

    task automatic check(string nm, logic [8:0] act, logic [8:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (wg rg ws rs busy err)", nm, act, exp);
    endtask

    task automatic apply(logic [2:0] w, logic [1:0] r, logic wd, logic rdn, logic cl);
        wr_req = w; rd_req = r; wr_done = wd; rd_done = rdn; timeout_clr = cl;
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        apply(0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clock);
        #1 check("reset", obs, 9'b0);
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(int w, int r, int wd, int rdn, int cl,
                                int eg, int er, int es, int ers, int eb, int ee);
        vec_t v;
        v.w = 3'(w); v.r = 2'(r); v.wd = 1'(wd); v.rdn = 1'(rdn); v.cl = 1'(cl);
        v.exp = {3'(eg), 2'(er), 1'(es), 1'(ers), 1'(eb), 1'(ee)};
        return v;
    endfunction

    vec_t tq[$];

    initial begin
        // alternation, done in first EXEC cycle, stray done pulses
        tq.push_back(mk(1,1,0,0,0, 1,0,1,0,1,0));
        repeat (3) tq.push_back(mk(1,1,0,0,0, 1,0,0,0,1,0));
        tq.push_back(mk(1,1,1,0,0, 0,0,0,0,0,0));
        tq.push_back(mk(1,1,0,0,0, 0,1,0,1,1,0));
        repeat (3) tq.push_back(mk(1,1,0,0,0, 0,1,0,0,1,0));
        tq.push_back(mk(1,1,0,1,0, 0,0,0,0,0,0));
        tq.push_back(mk(1,1,0,0,0, 1,0,1,0,1,0));
        tq.push_back(mk(1,1,1,0,0, 0,0,0,0,0,0));
        tq.push_back(mk(1,1,0,0,0, 0,1,0,1,1,0));
        tq.push_back(mk(1,1,1,0,0, 0,1,0,0,1,0));
        tq.push_back(mk(1,1,0,1,0, 0,0,0,0,0,0));
        tq.push_back(mk(0,0,1,0,0, 0,0,0,0,0,0));
        // watchdog expiry with request dropped, then clear
        tq.push_back(mk(0,2,0,0,0, 0,2,0,1,1,0));
        repeat (7) tq.push_back(mk(0,0,0,0,0, 0,2,0,0,1,0));
        tq.push_back(mk(0,0,0,0,0, 0,0,0,0,0,1));
        tq.push_back(mk(0,0,0,0,1, 0,0,0,0,0,0));
        // done coinciding with expiry is a normal completion
        tq.push_back(mk(0,1,0,0,0, 0,1,0,1,1,0));
        repeat (7) tq.push_back(mk(0,0,0,0,0, 0,1,0,0,1,0));
        tq.push_back(mk(0,0,0,1,0, 0,0,0,0,0,0));
        // expiry with clear in the same cycle: set wins
        tq.push_back(mk(0,2,0,0,0, 0,2,0,1,1,0));
        repeat (7) tq.push_back(mk(0,0,0,0,0, 0,2,0,0,1,0));
        tq.push_back(mk(0,0,0,0,1, 0,0,0,0,0,1));
        tq.push_back(mk(0,0,0,0,0, 0,0,0,0,0,1));
        // write round-robin including wrap past the last channel
        repeat (2) begin
            tq.push_back(mk(3,0,0,0,0, 2,0,1,0,1,1));
            tq.push_back(mk(3,0,1,0,0, 0,0,0,0,0,1));
            tq.push_back(mk(3,0,0,0,0, 1,0,1,0,1,1));
            tq.push_back(mk(3,0,1,0,0, 0,0,0,0,0,1));
        end
        tq.push_back(mk(4,0,0,0,0, 4,0,1,0,1,1));
        tq.push_back(mk(4,0,1,0,0, 0,0,0,0,0,1));
        tq.push_back(mk(7,0,0,0,0, 1,0,1,0,1,1));
        tq.push_back(mk(0,0,1,0,1, 0,0,0,0,0,0));

        do_reset();
        foreach (tq[i]) begin
            apply(tq[i].w, tq[i].r, tq[i].wd, tq[i].rdn, tq[i].cl);
            tick();
            check($sformatf("vec%0d", i + 1), obs, tq[i].exp);
        end

        // asynchronous reset in the middle of a write burst
        do_reset();
        apply(3'b001, 2'b00, 0, 0, 0);
        tick();
        check("ar_grant", obs, 9'b001_00_1010);
        tick();
        check("ar_hold", obs, 9'b001_00_0010);
        #2 rst_n = 1'b0;
        #1 check("ar_async", obs, 9'b0);
        model_reset();
        apply(3'b000, 2'b00, 1, 0, 0);
        @(negedge clock);
        rst_n = 1'b1;
        tick();
        check("ar_stray_done", obs, 9'b0);
        apply(3'b010, 2'b01, 0, 0, 0);
        tick();
        check("ar_write_first", obs, 9'b010_00_1010);
        apply(3'b010, 2'b01, 1, 0, 0);
        tick();
        check("ar_done", obs, mexp());

        // request dropped after one cycle; done five cycles after start
        do_reset();
        for (int k = 0; k < 8; k++) begin
            apply(k == 0 ? 3'b001 : 3'b000, 2'b00, k == 5, 0, 0);
            tick();
            check($sformatf("drop%0d", k), obs, mexp());
        end

        // randomized traffic with a varying burst length
        do_reset();
        for (int b = 0; b < 20; b++) begin
            int rate = $urandom_range(1, 12);
            for (int c = 0; c < 150; c++) begin
                apply(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                      $urandom_range(0, rate - 1) == 0, $urandom_range(0, rate - 1) == 0,
                      $urandom_range(0, 15) == 0);
                tick();
                check("rand", obs, mexp());
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/vdma_burst_scheduler.md
Name: vdma_burst_scheduler

Overview:
Arbiter that shares one AXI4 master burst engine between NUM_WR write channels and NUM_RD read channels of the VDMA.
- Alternates priority between directions: after a write burst completes, reads are preferred; after a read burst, writes are preferred.
- Round-robins among channels within each direction.
- Holds one grant until the engine reports the burst done.
- A watchdog recovers from a hung burst.
- Sits between the per-channel frame/line controllers and the shared AXI burst master.

Parameters:
NUM_WR, 2, number of write requesters (1..8)
NUM_RD, 2, number of read requesters (1..8)
TIMEOUT, 1024, maximum cycles a grant may be held before forced release (>=4)

Ports:
clock  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
wr_req  in  NUM_WR  per-channel write burst request, level
rd_req  in  NUM_RD  per-channel read burst request, level
wr_done  in  1  engine pulse: current write burst finished
rd_done  in  1  engine pulse: current read burst finished
timeout_clr  in  1  clears timeout_err
wr_grant  out  NUM_WR  one-hot write grant, registered
rd_grant  out  NUM_RD  one-hot read grant, registered
wr_start  out  1  1-cycle pulse in first cycle of wr_grant
rd_start  out  1  1-cycle pulse in first cycle of rd_grant
busy  out  1  high in WR_EXEC or RD_EXEC
timeout_err  out  1  sticky watchdog flag

Behaviour:
Reset (rst_n low, asynchronous):
- All outputs are 0.
- State is IDLE.
- pref_dir = WRITE.
- wr_ptr = 0 and rd_ptr = 0.
- Watchdog counter is 0.
- Reset mid-burst drops the grant immediately. The engine's later done pulse is ignored.

States:
- IDLE:
  - any_wr = |wr_req; any_rd = |rd_req.
  - If pref_dir = WRITE: go to WR_EXEC if any_wr, else RD_EXEC if any_rd, else stay.
  - If pref_dir = READ: mirror image.
- WR_EXEC:
  - wr_done -> IDLE, pref_dir <= READ.
  - Watchdog expiry -> IDLE, pref_dir <= READ.
- RD_EXEC:
  - rd_done -> IDLE, pref_dir <= WRITE.
  - Watchdog expiry -> IDLE, pref_dir <= WRITE.

Channel selection (on the IDLE->EXEC transition):
- Winner is the first asserted req scanning from ptr upward, wrapping modulo NUM_x.
- Winner index is latched. Grant bit is registered, so grant appears the cycle after IDLE samples req.
- start pulses in that same first grant cycle.

Grant hold and release:
- Grant holds for the whole EXEC state regardless of req changes; deasserting req does not withdraw the grant.
- On exit, ptr <= winner+1 (wrap to 0 at NUM_x). The grant is low in the next cycle (IDLE).
- Minimum one IDLE cycle between consecutive grants.
- A request is therefore granted 1 cycle after IDLE samples it. Back-to-back bursts cost done+2 cycles per slot.

Done pulse handling:
- wr_done is ignored outside WR_EXEC; rd_done is ignored outside RD_EXEC.
- Done arriving in the first EXEC cycle is legal and ends the burst.

Watchdog:
- Counter clears on EXEC entry and increments each EXEC cycle.
- When the counter reaches TIMEOUT-1 without done: force IDLE, set timeout_err, advance ptr as normal.
- Done in the same cycle as expiry counts as normal completion; timeout_err is not set.

timeout_err:
- Sticky.
- Cleared by timeout_clr; set wins if set and clear coincide.

busy = (state != IDLE), registered.

Test Plan:
- Write then read alternation: wr_req=01, rd_req=01 held; wr_done 3 cycles after each wr_start, rd_done likewise -> grants alternate wr_grant=01, rd_grant=01, wr_grant=01…; first wr_grant 1 cycle after reset release with req present.
- Round-robin within write: wr_req=11, rd_req=00, wr_done pulsed each burst -> wr_grant sequence 01,10,01,10; exactly one IDLE cycle between grants.
- Request drop during grant: wr_req=01 for 1 cycle only; wr_done pulsed 5 cycles after wr_start -> wr_grant stays 01 for 5 cycles, then 0; no new grant.
- Watchdog with TIMEOUT=8: rd_req=10, no rd_done -> rd_grant=10 for 8 cycles then drops, timeout_err=1; timeout_clr pulse -> timeout_err=0; rd_done in the expiry cycle -> timeout_err stays 0.
- Stray done pulses: wr_done pulsed in IDLE and during RD_EXEC -> no state change, rd_grant held until rd_done.
- Async reset mid-burst: rst_n low during WR_EXEC -> all outputs 0 immediately; after release with wr_req=10, rd_req=01 -> write granted first (pref_dir=WRITE), channel 1, via wr_grant=10.
